// File: rtl/apb_master_bridge_if.sv
// Local command/response port plus APB requester bus of apb_master_bridge.
// The master modport is the bridge side; the slave modport is the environment side.
interface apb_master_bridge_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one command at a time through SETUP/ACCESS, one response pulse per command,
// with an ACCESS-phase timeout guarding against a hung slave. All outputs are registered.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  apb_master_bridge_if.master bus
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              exit_access;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = 1'b0;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    exit_access   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d       = '0;
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = cnt_inc;
        // pslverr beats pready, and either beats a timeout in the same cycle.
        if (bus.pslverr) begin
          exit_access = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (bus.pready) begin
          exit_access = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
        end else if (cnt_inc == TimeoutCnt) begin
          exit_access   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
        if (exit_access) begin
          state_d     = StIdle;
          cnt_d       = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: registered APB slave with wait/error/hang modes, a
// transaction-level reference model checked every cycle, and directed literal checks.
module tb_apb_master_bridge;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 100000", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Slave: registered pready/pslverr, which linger one cycle after penable drops.
  int         slv_waits = 0;
  bit         slv_err   = 1'b0;
  bit         slv_hang  = 1'b0;
  int         wcnt;
  bit         mem_init  = 1'b0;
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_init <= 1'b1;
    end
    if (reset) begin
      bus.pready  <= 1'b0;
      bus.pslverr <= 1'b0;
      bus.prdata  <= '0;
      wcnt        <= 0;
    end else if (bus.psel && bus.penable) begin
      if (wcnt >= slv_waits && !slv_hang) begin
        if (slv_err) begin
          bus.pslverr <= 1'b1;
        end else begin
          bus.pready <= 1'b1;
          if (bus.pwrite) mem[bus.paddr] <= bus.pwdata;
          else            bus.prdata     <= mem[bus.paddr];
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      bus.pready  <= 1'b0;
      bus.pslverr <= 1'b0;
      wcnt        <= 0;
    end
  end

  // Reference model: a busy flag and the age of the transfer in cycles since accept.
  logic       e_cmd_ready, e_psel, e_pen, e_pwrite, e_rsp_valid, e_err, e_to;
  logic [7:0] e_paddr, e_pwdata, e_rdata;
  logic [7:0] shadow [256];
  bit         busy = 1'b0;
  int         age = 0;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      e_rsp_valid = 1'b0;
      e_rdata     = '0;
      e_err       = 1'b0;
      e_to        = 1'b0;
      if (reset) begin
        busy = 1'b0; age = 0;
        e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
        e_cmd_ready = 1'b0; e_psel = 1'b0; e_pen = 1'b0;
      end else begin
        if (!busy) begin
          if (bus.cmd_valid && e_cmd_ready) begin
            busy = 1'b1; age = 1;
            e_pwrite = bus.cmd_write; e_paddr = bus.cmd_addr; e_pwdata = bus.cmd_wdata;
          end
        end else if (age < 2) begin
          age++;
        end else if (bus.pslverr) begin
          busy = 1'b0; e_rsp_valid = 1'b1; e_err = 1'b1;
        end else if (bus.pready) begin
          busy = 1'b0; e_rsp_valid = 1'b1;
          if (e_pwrite) shadow[e_paddr] = e_pwdata;
          else          e_rdata = shadow[e_paddr];
        end else if (age - 1 == TIMEOUT) begin
          busy = 1'b0; e_rsp_valid = 1'b1; e_err = 1'b1; e_to = 1'b1;
        end else begin
          age++;
        end
        e_cmd_ready = !busy;
        e_psel      = busy;
        e_pen       = busy && age >= 2;
      end
    end
  end

  // Monitor and per-cycle compare on the falling edge.
  int         psel_rise = 0, pen_rise = 0, low_run = 0, last_gap = 0, rsp_count = 0;
  logic       psel_prev = 1'b0, pen_prev = 1'b0;
  logic [9:0] rsp_log [$];

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("cycle_outputs",
              {1'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
               bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
              {1'b0, e_cmd_ready, e_rsp_valid, e_rdata, e_err, e_to,
               e_psel, e_pen, e_pwrite, e_paddr, e_pwdata});
      end
      if (bus.psel === 1'b1 && !psel_prev) begin
        psel_rise = cyc;
        last_gap  = low_run;
      end
      if (bus.penable === 1'b1 && !pen_prev) pen_rise = cyc;
      if (bus.psel === 1'b1) low_run = 0;
      else                   low_run++;
      psel_prev = (bus.psel === 1'b1);
      pen_prev  = (bus.penable === 1'b1);
      if (bus.rsp_valid === 1'b1) begin
        rsp_count++;
        rsp_log.push_back({bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata});
      end
    end
  end

  int acc;

  // Call at a falling edge or just after a rising edge; returns 1 time unit after accept.
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, input bit hold);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_accept: cmd_ready got 0 for 50 cycles required 1");
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int bound, output int at);
    int  n = 0;
    bit  seen = 1'b0;
    at = -1;
    while (!seen && n < bound) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
      n++;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_rsp_wait: got no rsp_valid in %0d cycles required one", name, bound);
    end
  endtask

  int rsp_at, saved;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
               bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.cmd_ready), 32'h1);

    // Zero-wait write: psel on the accept edge, penable one edge later, response on the 3rd.
    send(1'b1, 8'h10, 8'hA5, 1'b0);
    wait_rsp("t1", 40, rsp_at);
    check("t1_psel_delay", 32'(psel_rise - acc), 32'd0);
    check("t1_penable_delay", 32'(pen_rise - acc), 32'd1);
    check("t1_rsp_delay", 32'(rsp_at - acc), 32'd3);
    check("t1_err", 32'(bus.rsp_err), 32'h0);
    check("t1_rdata", 32'(bus.rsp_rdata), 32'h0);

    send(1'b0, 8'h10, 8'h00, 1'b0);
    wait_rsp("t2", 40, rsp_at);
    check("t2_rdata", 32'(bus.rsp_rdata), 32'hA5);
    check("t2_err", 32'(bus.rsp_err), 32'h0);

    slv_err = 1'b1;
    send(1'b0, 8'hFF, 8'h00, 1'b0);
    wait_rsp("t3", 40, rsp_at);
    check("t3_err_to_rdata", 32'({bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}), 32'h200);
    slv_err = 1'b0;

    // Hung slave: 1 SETUP + 16 ACCESS cycles of psel, dropped on the response edge.
    slv_hang = 1'b1;
    send(1'b1, 8'h30, 8'h77, 1'b0);
    wait_rsp("t4", 60, rsp_at);
    check("t4_err_to", 32'({bus.rsp_err, bus.rsp_timeout}), 32'h3);
    check("t4_psel_cycles", 32'(rsp_at - psel_rise), 32'd17);
    check("t4_psel_dropped", 32'(bus.psel), 32'h0);
    slv_hang = 1'b0;

    // cmd_valid held across two commands.
    saved = rsp_count;
    send(1'b1, 8'h20, 8'h3C, 1'b1);
    send(1'b0, 8'h20, 8'h00, 1'b0);
    wait_rsp("t5", 40, rsp_at);
    check("t5_rsp_count", 32'(rsp_count - saved), 32'd2);
    check("t5_first_rsp", 32'(rsp_log[rsp_log.size() - 2]), 32'h000);
    check("t5_second_rsp", 32'(rsp_log[rsp_log.size() - 1]), 32'h03C);
    check("t5_psel_gap", 32'(last_gap), 32'd1);

    // Reset while in ACCESS, then a 3-wait read.
    slv_hang = 1'b1;
    send(1'b0, 8'h40, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    saved = rsp_count;
    reset = 1'b1;
    @(negedge clk);
    check("t6_in_reset", 32'({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid}), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready_release", 32'(bus.cmd_ready), 32'h1);
    repeat (4) @(negedge clk);
    check("t6_no_rsp", 32'(rsp_count - saved), 32'd0);
    slv_hang  = 1'b0;
    slv_waits = 3;
    send(1'b0, 8'h10, 8'h00, 1'b0);
    wait_rsp("t6", 40, rsp_at);
    check("t6_rdata", 32'(bus.rsp_rdata), 32'hA5);
    check("t6_rsp_delay", 32'(rsp_at - acc), 32'd6);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
